// File: rtl/sctag_pcx_iq_ctl_pkg.sv
// Shared constants for the PCX->sctag input queue: packet width and the
// layout of a buffered FIFO entry ({atm, payload}, atm flag in the MSB).
package sctag_pcx_iq_ctl_pkg;

    localparam int PCX_WIDTH  = 164;
    localparam int IQ_ENT_W   = PCX_WIDTH + 1;
    localparam int IQ_ATM_BIT = IQ_ENT_W - 1;

    // Head is issuable unless it is the first half of an atomic pair whose
    // partner has not been buffered yet.
    function automatic logic iq_issuable(input logic has_one,
                                         input logic has_two,
                                         input logic head_atm);
        return has_one & (~head_atm | has_two);
    endfunction

endpackage

// File: rtl/sctag_iq_fifo.sv
// Small flop-array FIFO: storage, read/write pointers and occupancy count.
// Data storage has no reset; the count and pointers define validity.
// The read port is combinational from the head entry.
module sctag_iq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 165,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Per-entry write enable decoded from the tail pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the incoming entry when this slot is the tail.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Occupancy follows writes and pops; simultaneous ones cancel.
    always_comb begin
        cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign cnt     = cnt_q;

endmodule

// File: rtl/sctag_pcx_iq_ctl.sv
// Input-queue controller for PCX->sctag packets. Stages the px1 strobes,
// writes px2 packets into a small FIFO, issues the head to the pipe arbiter
// (holding an atomic first half until its partner is buffered), and drives
// a registered stall back to the PCX with skid margin.
module sctag_pcx_iq_ctl
    import sctag_pcx_iq_ctl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SKID  = 2,
    parameter int PW    = PCX_WIDTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          rclk,
    input  logic          reset,
    input  logic          pcx_sctag_data_rdy_px1,
    input  logic          pcx_sctag_atm_px1,
    input  logic [PW-1:0] pcx_sctag_data_px2,
    input  logic          arb_iq_grant,
    output logic          sctag_pcx_stall_pq,
    output logic          iq_arb_vld,
    output logic          iq_arb_atm,
    output logic [PW-1:0] iq_arb_pkt,
    output logic [CW-1:0] iq_cnt,
    output logic          iq_ovfl_err
);

    localparam int EW = PW + 1;

    logic          rdy_px2_q;
    logic          atm_px2_q;
    logic          stall_q;
    logic          ovfl_err_q;

    logic [EW-1:0] head_ent;
    logic          head_atm;
    logic [CW-1:0] cnt;
    logic          vld;
    logic          pop;
    logic          wr_acc;
    logic [CW-1:0] cnt_nxt;

    sctag_iq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .CW    (CW)
    ) u_fifo (
        .clk     (rclk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_data ({atm_px2_q, pcx_sctag_data_px2}),
        .rd_en   (pop),
        .rd_data (head_ent),
        .cnt     (cnt)
    );

    // Issue rule, pop and accept/drop decision for the px2 packet.
    always_comb begin
        head_atm = head_ent[EW-1];
        vld      = iq_issuable(cnt != '0, cnt >= CW'(2), head_atm);
        pop      = arb_iq_grant & vld;
        // A full queue still accepts when the head leaves in the same cycle.
        wr_acc   = rdy_px2_q & ((cnt < CW'(DEPTH)) | pop);
        cnt_nxt  = cnt + CW'(wr_acc) - CW'(pop);
    end

    // px1->px2 staging, registered stall and sticky overflow error.
    always_ff @(posedge rclk) begin
        if (reset) begin
            rdy_px2_q  <= 1'b0;
            atm_px2_q  <= 1'b0;
            stall_q    <= 1'b0;
            ovfl_err_q <= 1'b0;
        end else begin
            rdy_px2_q <= pcx_sctag_data_rdy_px1;
            atm_px2_q <= pcx_sctag_data_rdy_px1 & pcx_sctag_atm_px1;
            stall_q   <= (cnt_nxt >= CW'(DEPTH - SKID));
            if (rdy_px2_q && !wr_acc) begin
                ovfl_err_q <= 1'b1;
            end
        end
    end

    assign sctag_pcx_stall_pq = stall_q;
    assign iq_arb_vld         = vld;
    assign iq_arb_atm         = vld & head_atm;
    assign iq_arb_pkt         = head_ent[PW-1:0];
    assign iq_cnt             = cnt;
    assign iq_ovfl_err        = ovfl_err_q;

endmodule

// File: tb/tb_sctag_pcx_iq_ctl.sv
// Bench for sctag_pcx_iq_ctl: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_sctag_pcx_iq_ctl;

    localparam int DEPTH = 4;
    localparam int SKID  = 2;
    localparam int PW    = 164;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          rclk = 1'b0;
    logic          reset = 1'b1;
    logic          rdy_px1 = 1'b0;
    logic          atm_px1 = 1'b0;
    logic [PW-1:0] data_px2 = '0;
    logic          grant = 1'b0;
    logic          stall;
    logic          vld;
    logic          atm;
    logic [PW-1:0] pkt;
    logic [CW-1:0] cnt;
    logic          ovfl_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 rclk = ~rclk;

    sctag_pcx_iq_ctl #(.DEPTH(DEPTH), .SKID(SKID), .PW(PW)) dut (
        .rclk                   (rclk),
        .reset                  (reset),
        .pcx_sctag_data_rdy_px1 (rdy_px1),
        .pcx_sctag_atm_px1      (atm_px1),
        .pcx_sctag_data_px2     (data_px2),
        .arb_iq_grant           (grant),
        .sctag_pcx_stall_pq     (stall),
        .iq_arb_vld             (vld),
        .iq_arb_atm             (atm),
        .iq_arb_pkt             (pkt),
        .iq_cnt                 (cnt),
        .iq_ovfl_err            (ovfl_err)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic          atm;
        logic [PW-1:0] pkt;
    } ent_t;

    ent_t q[$];          // expected FIFO contents, head at index 0
    bit   m_err = 0;
    bit   m_stall = 0;
    bit   m_px2 = 0;     // a packet is due on data_px2 this cycle
    bit   m_atm2 = 0;
    bit   m_started = 0;
    bit   m_v, m_pop, m_acc;
    int   n_issued = 0;

    function automatic bit exp_vld();
        if (q.size() == 0) return 1'b0;
        if (!q[0].atm) return 1'b1;
        return q.size() >= 2;
    endfunction

    always @(posedge rclk) begin
        if (reset) begin
            q.delete();
            m_err   = 0;
            m_stall = 0;
            m_px2   = 0;
            m_atm2  = 0;
        end else begin
            m_v   = exp_vld();
            m_pop = grant && m_v;
            m_acc = m_px2 && ((q.size() < DEPTH) || m_pop);
            if (m_pop) begin
                $display("issue #%0d pkt[31:0]=%h atm=%0d cnt_before=%0d",
                         n_issued, q[0].pkt[31:0], q[0].atm, q.size());
                n_issued++;
                void'(q.pop_front());
            end
            if (m_acc) q.push_back('{m_atm2, data_px2});
            if (m_px2 && !m_acc) m_err = 1;
            m_stall = (q.size() >= DEPTH - SKID);
            m_px2   = rdy_px1;
            m_atm2  = rdy_px1 && atm_px1;
        end
        m_started = 1;
    end

    // ---------------- monitor / scoreboard compare ----------------
    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    endtask

    always @(negedge rclk) begin
        if (m_started) begin
            bit ev;
            ev = exp_vld();
            check("vld",   PW'(vld),      PW'(ev));
            check("atm",   PW'(atm),      PW'(ev && q[0].atm));
            check("cnt",   PW'(cnt),      PW'(q.size()));
            check("stall", PW'(stall),    PW'(m_stall));
            check("ovfl",  PW'(ovfl_err), PW'(m_err));
            if (ev) check("pkt", pkt, q[0].pkt);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [PW-1:0] rnd_pkt();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    // One cycle of stimulus; data_px2 always carries fresh random payload so
    // the model must capture exactly the cycle the DUT writes.
    task automatic step(input bit r, input bit a, input bit g, input bit rst = 0);
        @(negedge rclk);
        reset    = rst;
        rdy_px1  = r;
        atm_px1  = a;
        grant    = g;
        data_px2 = rnd_pkt();
    endtask

    initial begin
        int p_rdy, p_gnt;
        bit partner_due;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // single packet, grant held high
        step(1, 0, 1);
        @(negedge rclk) data_px2 = PW'(8'hA5);
        repeat (3) step(0, 0, 1);

        // stall threshold, fill to DEPTH, overflow with no grant
        repeat (4) step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        // write arriving while full, with grant in the same cycle
        step(0, 0, 0, 1);
        repeat (4) step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        repeat (5) step(0, 0, 1);

        // atomic hold: partner three cycles later
        step(1, 1, 0);
        repeat (2) step(0, 0, 0);
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        repeat (3) step(0, 0, 1);

        // streaming with grant every cycle, then grants on an empty queue
        repeat (10) step(1, 0, 1);
        repeat (4) step(0, 0, 1);

        // reset mid-operation with stall, error and an rdy during reset
        repeat (5) step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 1, 0, 1);
        repeat (3) step(0, 0, 0);

        // randomized traffic with varying load
        partner_due = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                p_rdy = $urandom_range(20, 90);
                p_gnt = $urandom_range(10, 95);
            end
            if (i % 500 == 499) begin
                step(0, 0, 0, 1);
                partner_due = 0;
            end else begin
                bit r, a;
                r = ($urandom_range(0, 99) < p_rdy);
                a = r && !partner_due && ($urandom_range(0, 99) < 20);
                if (r) partner_due = a;
                step(r, a, $urandom_range(0, 99) < p_gnt);
            end
        end
        repeat (8) step(0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
